// File: rtl/mem_port_pkg.sv
// Shared types and helpers for strobe/ack/retry memory port initiators.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } port_state_e;

  function automatic int word_bits(input int byte_bits, input int bytes_per_word);
    return byte_bits * bytes_per_word;
  endfunction

endpackage

// File: rtl/mem_port_initiator.sv
// Single-outstanding initiator for the strobe/ack/retry memory port: one strobe per
// attempt, reissue on retry, completion or error pulse back to the client.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int BYTE_BITS      = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_BITS      = 10,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int WORD_BITS     = word_bits(BYTE_BITS, BYTES_PER_WORD)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic [WORD_BITS-1:0]      req_data,
  input  logic [BYTES_PER_WORD-1:0] req_select,
  input  logic                      req_write,
  output logic                      resp_valid,
  output logic [WORD_BITS-1:0]      resp_data,
  output logic                      resp_error,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [WORD_BITS-1:0]      mem_out,
  output logic [BYTES_PER_WORD-1:0] mem_select,
  output logic                      mem_write,
  output logic                      mem_strobe,
  input  logic [WORD_BITS-1:0]      mem_in,
  input  logic                      mem_ack,
  input  logic                      mem_retry
);

  // A zero-retry configuration still needs a one-bit counter to keep the compare legal.
  localparam int RETRY_BITS = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TMO_BITS   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RETRY_BITS-1:0] RETRY_LIMIT = RETRY_BITS'(MAX_RETRIES);
  localparam logic [TMO_BITS-1:0]   TMO_LIMIT   = TMO_BITS'(TIMEOUT_CYCLES);

  port_state_e           state;
  port_state_e           next_state;
  logic [RETRY_BITS-1:0] retry_cnt;
  logic [TMO_BITS-1:0]   tmo_cnt;
  logic                  error_q;
  logic                  retry_exhausted;
  logic                  timed_out;

  assign retry_exhausted = (retry_cnt == RETRY_LIMIT);
  assign timed_out       = (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      error_q    <= 1'b0;
      resp_data  <= '0;
      mem_addr   <= '0;
      mem_out    <= '0;
      mem_select <= '0;
      mem_write  <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr   <= req_addr;
            mem_out    <= req_data;
            mem_select <= req_select;
            mem_write  <= req_write;
            resp_data  <= '0;
            error_q    <= 1'b0;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (!timed_out) begin
            tmo_cnt <= tmo_cnt + TMO_BITS'(1);
          end
          // Ack takes priority over a simultaneous retry and over the timeout.
          if (mem_ack) begin
            if (!mem_write) begin
              resp_data <= mem_in;
            end
          end else if (mem_retry) begin
            if (retry_exhausted) begin
              error_q <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + RETRY_BITS'(1);
            end
          end else if (timed_out) begin
            error_q <= 1'b1;
          end
        end
        RESP: retry_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (mem_ack) begin
          next_state = RESP;
        end else if (mem_retry) begin
          next_state = retry_exhausted ? RESP : ISSUE;
        end else if (timed_out) begin
          next_state = RESP;
        end
      end
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_strobe = (state == ISSUE);
    resp_valid = (state == RESP);
    resp_error = (state == RESP) && error_q;
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Randomised scoreboard bench for mem_port_initiator with a behavioural responder
// (variable latency, ping-pong, retry-forever, silent) and a reference memory.
module tb_mem_port_initiator;

  localparam int BYTE_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_BITS      = 10;
  localparam int MAX_RETRIES    = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int WORD_BITS      = BYTE_BITS * BYTES_PER_WORD;

  localparam int M_NORMAL = 0;
  localparam int M_PING   = 1;
  localparam int M_BOTH   = 2;
  localparam int M_RETRY  = 3;
  localparam int M_NEVER  = 4;

  logic                      clock;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_BITS-1:0]      req_addr;
  logic [WORD_BITS-1:0]      req_data;
  logic [BYTES_PER_WORD-1:0] req_select;
  logic                      req_write;
  logic                      resp_valid;
  logic [WORD_BITS-1:0]      resp_data;
  logic                      resp_error;
  logic [ADDR_BITS-1:0]      mem_addr;
  logic [WORD_BITS-1:0]      mem_out;
  logic [BYTES_PER_WORD-1:0] mem_select;
  logic                      mem_write;
  logic                      mem_strobe;
  logic [WORD_BITS-1:0]      mem_in;
  logic                      mem_ack;
  logic                      mem_retry;

  mem_port_initiator #(
    .BYTE_BITS(BYTE_BITS),
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .ADDR_BITS(ADDR_BITS),
    .MAX_RETRIES(MAX_RETRIES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_select(req_select),
    .req_write(req_write),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_error(resp_error),
    .mem_addr(mem_addr),
    .mem_out(mem_out),
    .mem_select(mem_select),
    .mem_write(mem_write),
    .mem_strobe(mem_strobe),
    .mem_in(mem_in),
    .mem_ack(mem_ack),
    .mem_retry(mem_retry)
  );

  typedef struct {
    logic [WORD_BITS-1:0] data;
    logic                 err;
    int                   strobes;
    int                   lat;
  } exp_t;

  exp_t           exp_q[$];
  logic [31:0]    ref_mem [1024];
  logic [31:0]    resp_mem [1024];
  int             errors = 0;
  int             checks = 0;
  int             cyc = 0;
  int             resp_mode;
  int             resp_lat;
  int             stray_cyc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: sees the strobe at the negedge and answers resp_lat cycles later.
  int             pend;
  int             cnt;
  int             answer_retry;
  int             answer_both;
  int             rsp_strobes;
  logic [9:0]     p_addr;
  logic [31:0]    p_data;
  logic [3:0]     p_sel;
  logic           p_write;

  initial begin
    pend = 0;
    cnt = 0;
    answer_retry = 0;
    answer_both = 0;
    rsp_strobes = 0;
    mem_ack = 1'b0;
    mem_retry = 1'b0;
    mem_in = '0;
  end

  always @(negedge clock) begin
    mem_ack = 1'b0;
    mem_retry = 1'b0;
    mem_in = $urandom;
    if (req_ready) rsp_strobes = 0;
    if (cyc == stray_cyc) mem_ack = 1'b1;
    if (reset) pend = 0;
    if (pend != 0) begin
      if (cnt <= 1) begin
        pend = 0;
        if (answer_retry != 0) begin
          mem_retry = 1'b1;
        end else begin
          mem_ack = 1'b1;
          if (answer_both != 0) mem_retry = 1'b1;
          if (p_write) begin
            for (int b = 0; b < 4; b++)
              if (p_sel[b]) resp_mem[p_addr][b*8 +: 8] = p_data[b*8 +: 8];
          end else begin
            mem_in = resp_mem[p_addr];
          end
        end
      end else begin
        cnt--;
      end
    end
    if (mem_strobe && !reset && resp_mode != M_NEVER) begin
      p_addr = mem_addr;
      p_data = mem_out;
      p_sel = mem_select;
      p_write = mem_write;
      pend = 1;
      cnt = resp_lat;
      answer_both = (resp_mode == M_BOTH) ? 1 : 0;
      answer_retry = (resp_mode == M_RETRY || (resp_mode == M_PING && rsp_strobes == 0)) ? 1 : 0;
      rsp_strobes++;
    end
  end

  // Monitor: counts strobes per accepted request and scores each completion.
  int   accept_cyc = 0;
  int   strobe_cnt = 0;
  logic prev_strobe = 1'b0;

  always @(negedge clock) begin
    if (req_valid && req_ready && !reset) begin
      accept_cyc = cyc;
      strobe_cnt = 0;
    end
    if (mem_strobe) begin
      strobe_cnt++;
      check_output("strobe_gap", {31'b0, prev_strobe}, 32'd0);
    end
    prev_strobe = mem_strobe;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("resp_data", resp_data, e.data);
        check_output("resp_error", {31'b0, resp_error}, {31'b0, e.err});
        check_output("strobe_count", strobe_cnt, e.strobes);
        check_output("latency", cyc - accept_cyc, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got req_ready=0 expected 1");
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clock);
      k++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [9:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int mode, input int lat);
    exp_t        e;
    int          n;
    logic [31:0] m;
    wait_ready();
    resp_mode = mode;
    resp_lat = lat;
    n = (mode == M_PING) ? 2 : (mode == M_RETRY) ? MAX_RETRIES + 1 : 1;
    e.strobes = n;
    e.lat = (mode == M_NEVER) ? TIMEOUT_CYCLES + 3 : n * (lat + 1) + 1;
    if (mode == M_RETRY || mode == M_NEVER) begin
      e.err = 1'b1;
      e.data = '0;
    end else begin
      e.err = 1'b0;
      if (wr) begin
        e.data = '0;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      end else begin
        e.data = ref_mem[a];
      end
    end
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_data = d;
    req_select = s;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr = 10'($urandom);
    req_data = $urandom;
    req_select = 4'($urandom);
    req_write = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_select = '0;
    req_write = 1'b0;
    resp_mode = M_NORMAL;
    resp_lat = 1;
    stray_cyc = -1;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      resp_mem[i] = v;
    end
    ref_mem[5] = 32'hDEADBEEF;
    resp_mem[5] = 32'hDEADBEEF;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset_ready", {31'b0, req_ready}, 32'd1);
    check_output("reset_strobe", {31'b0, mem_strobe}, 32'd0);
    check_output("reset_valid", {31'b0, resp_valid}, 32'd0);
    check_output("reset_error", {31'b0, resp_error}, 32'd0);
    check_output("reset_data", resp_data, 32'd0);
    check_output("reset_addr", {22'b0, mem_addr}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    apply_stimulus(1'b0, 10'd5, 32'd0, 4'h0, M_NORMAL, 1);
    apply_stimulus(1'b1, 10'd3, 32'h11223344, 4'b0101, M_NORMAL, 1);
    check_output("write_lane0", {24'b0, resp_mem[3][7:0]}, 32'h44);
    check_output("write_lane2", {24'b0, resp_mem[3][23:16]}, 32'h22);
    check_output("write_word", resp_mem[3], ref_mem[3]);
    apply_stimulus(1'b0, 10'd3, 32'd0, 4'h0, M_NORMAL, 4);
    apply_stimulus(1'b0, 10'd5, 32'd0, 4'h0, M_PING, 5);
    apply_stimulus(1'b1, 10'd7, 32'hCAFEF00D, 4'hF, M_RETRY, 2);
    apply_stimulus(1'b0, 10'd7, 32'd0, 4'h0, M_NORMAL, 7);
    apply_stimulus(1'b0, 10'd9, 32'd0, 4'h0, M_NEVER, 1);

    stray_cyc = cyc;
    repeat (3) @(posedge clock);
    #1;
    check_output("stray_ack_ready", {31'b0, req_ready}, 32'd1);
    check_output("stray_ack_strobe", {31'b0, mem_strobe}, 32'd0);

    apply_stimulus(1'b0, 10'd5, 32'd0, 4'h0, M_BOTH, 3);

    wait_ready();
    resp_mode = M_NEVER;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 10'd5;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_output("abort_ready", {31'b0, req_ready}, 32'd1);
    check_output("abort_strobe", {31'b0, mem_strobe}, 32'd0);
    check_output("abort_valid", {31'b0, resp_valid}, 32'd0);
    repeat (TIMEOUT_CYCLES + 6) @(posedge clock);
    #1;
    apply_stimulus(1'b0, 10'd5, 32'd0, 4'h0, M_NORMAL, 1);

    for (int t = 0; t < 40; t++) begin
      int r;
      int mode;
      int lat;
      r = $urandom_range(0, 19);
      if (r <= 12) mode = M_NORMAL;
      else if (r <= 15) mode = M_PING;
      else if (r <= 17) mode = M_BOTH;
      else if (r == 18) mode = M_RETRY;
      else mode = M_NEVER;
      lat = (mode == M_RETRY) ? $urandom_range(1, 3) : $urandom_range(1, 7);
      apply_stimulus(1'($urandom), 10'($urandom_range(0, 15)), $urandom,
                     4'($urandom), mode, lat);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    repeat (5) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
